spi_slv16: RTL
==============

# spi_slv16

16-bit SPI slave (responder) that is the far end of the team's 16-bit SPI master link. It runs on the fast system clock and oversamples SS_n, SCLK and MOSI. It returns a pre-loaded 16-bit response on MISO, MSB first, while capturing the master's 16-bit command. It sits in slave-side peripherals and in the bench as the master's loopback partner, and reports each complete command with a one-cycle `rdy` pulse.

## Interface
- SPI_W, 16, frame width in bits. Fixed at 16; kept as a parameter for readability only.
- clk  input  1  system clock; all logic rising-edge.
- rst  input  1  asynchronous, active-high reset.
- SS_n  input  1  slave select from master, active low, asynchronous to clk.
- SCLK  input  1  serial clock from master; idles high; asynchronous to clk.
- MOSI  input  1  master-out data; changes on SCLK fall.
- MISO  output  1  slave-out data; equals tx shift register bit 15.
- wrt  input  1  one-cycle strobe; loads `tx_data` into the response buffer.
- tx_data  input  16  response word for the next frame.
- cmd_rcvd  output  16  last complete command received; holds until the next good frame.
- rdy  output  1  one-cycle pulse: `cmd_rcvd` was just updated.
- err  output  1  one-cycle pulse: frame ended with a bit count other than 16.

## Operation
- Synchronization:
  - SS_n, SCLK and MOSI each pass through 2 flops, plus a third flop for edge detect.
  - ss_fall, ss_rise, sclk_rise and sclk_fall are derived from the sync2/sync3 pairs.
  - Sync flops reset to 1, so idle-high lines create no edge at reset release.
- State machine, 2 states:
  - IDLE: on ss_fall, load shft <= tx_buf, clear bit_cnt, go to ACTIVE. SCLK edges are ignored.
  - ACTIVE, on sclk_rise: mosi_smpl <= synced MOSI; bit_cnt increments, saturating at 17.
  - ACTIVE, on sclk_fall with bit_cnt in 1..15: shft <= {shft[14:0], mosi_smpl}.
  - ACTIVE, other falls: ignored. This covers the fall before the first rise and falls after the 16th rise.
  - ACTIVE, on ss_rise: if bit_cnt==16, cmd_rcvd <= {shft[14:0], mosi_smpl} and pulse rdy; otherwise pulse err and leave cmd_rcvd unchanged. Then go to IDLE.
- The master generates no final SCLK fall after the 16th rise. Only 15 shifts occur, and the last bit comes from mosi_smpl.
- tx_buf: written on wrt in any state. A write during ACTIVE affects only the next frame. wrt on the same cycle as ss_fall: the new tx_data is loaded directly into shft.
- MISO is registered as shft[15] and is driven in all states (no tristate).
- ss_rise and sclk_rise in the same cycle: process the sample first, then evaluate the frame end with the updated count.

## Timing
- Reset values: MISO=0, cmd_rcvd=0, rdy=0, err=0, tx_buf=0, shft=0, bit_cnt=0, state=IDLE.
- Pin-to-action latency: a pin transition is sampled at clk edge k, and the resulting register update occurs at edge k+2.
  - MISO changes on edge k+3 after the SCLK fall pin edge.
  - The master half-period is 16 clk, so MISO is stable at the master's sample point.
- rdy/err: high for exactly one cycle, 3 clk after SS_n rises at the pin. cmd_rcvd is valid in the same cycle as rdy.
- First MISO bit (tx_data[15]) is valid 3 clk after SS_n falls, well before the first SCLK rise (master front porch).
- rst asserted mid-frame: immediate return to reset values with no rdy and no err.
- SS_n low at reset release: a false ss_fall starts a partial frame, which ends in err.

## Structure
- `spi_pkg` holds:
  - `spi_slv_state_t` enum {IDLE, ACTIVE}.
  - localparam SPI_W=16.
  - localparam BIT_CNT_W=5 with BIT_CNT_MAX=17.
- Sub-module `sync_edge`: 3-flop synchronizer with parameterized reset value; outputs sync level, rise and fall. Instantiated for SS_n and SCLK.
- MOSI uses a plain 2-flop sync of matching depth so it aligns with sclk_rise.

## Test plan
- Basic frame: wrt with tx_data=16'hA5C3; master sends cmd=16'h1234 -> master rd_data=16'hA5C3, cmd_rcvd=16'h1234, one rdy pulse, err=0.
- Back-to-back frames: tx 16'hFFFF then 16'h0001, cmd 16'h8000 then 16'h7FFF -> each frame returns its own word, and two rdy pulses follow the respective SS_n rises.
- wrt of 16'hDEAD mid-frame with 16'hBEEF loaded -> current frame returns 16'hBEEF; next frame returns 16'hDEAD.
- Short frame: SS_n raised after 9 SCLK rises -> err pulse, no rdy, cmd_rcvd keeps its prior value 16'h1234.
- rst pulsed after 8 bits -> all outputs 0; next full frame with cmd 16'h00FF yields cmd_rcvd=16'h00FF and rdy.
- Long frame: 17 SCLK rises before SS_n rises -> err pulse, cmd_rcvd unchanged.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the 16-bit SPI slave.
// Provides the FSM state enum and frame/bit-count sizing.
package spi_pkg;

  localparam int SPI_W = 16;
  localparam int BIT_CNT_W = 5;
  localparam logic [BIT_CNT_W-1:0] BIT_CNT_MAX = 5'd17;

  typedef enum logic {
    IDLE,
    ACTIVE
  } spi_slv_state_t;

endpackage

// File: rtl/spi_slv16_sync_edge.sv
// 3-flop synchronizer with edge detect for an async input.
// Ports: clk, rst, d_i (async in), lvl_o (synced), rise_o, fall_o.
module sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
      s3_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign lvl_o  = s2_q;
  assign rise_o = s2_q & ~s3_q;
  assign fall_o = ~s2_q & s3_q;

endmodule

// File: rtl/spi_slv16.sv
// 16-bit SPI slave: returns a preloaded word on MISO, captures the command.
// Ports: clk, rst, SS_n, SCLK, MOSI, MISO, wrt, tx_data, cmd_rcvd, rdy, err.
module spi_slv16 #(
  parameter int SPI_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SS_n,
  input  logic             SCLK,
  input  logic             MOSI,
  output logic             MISO,
  input  logic             wrt,
  input  logic [SPI_W-1:0] tx_data,
  output logic [SPI_W-1:0] cmd_rcvd,
  output logic             rdy,
  output logic             err
);

  import spi_pkg::*;

  logic ss_lvl, ss_rise, ss_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi1_q, mosi2_q;
  logic unused_lvl;

  spi_slv_state_t       state_q;
  logic [SPI_W-1:0]     tx_buf_q;
  logic [SPI_W-1:0]     shft_q;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic                 mosi_smpl_q, mosi_smpl_d;
  logic                 shift_ok;

  sync_edge #(.RST_VAL(1'b1)) u_ss (
    .clk    (clk),
    .rst    (rst),
    .d_i    (SS_n),
    .lvl_o  (ss_lvl),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  sync_edge #(.RST_VAL(1'b1)) u_sclk (
    .clk    (clk),
    .rst    (rst),
    .d_i    (SCLK),
    .lvl_o  (sclk_lvl),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  assign unused_lvl = ss_lvl ^ sclk_lvl;

  // Two flops only, so mosi2_q lines up with sclk_rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi1_q <= 1'b1;
      mosi2_q <= 1'b1;
    end else begin
      mosi1_q <= MOSI;
      mosi2_q <= mosi1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_buf_q <= '0;
    else if (wrt) tx_buf_q <= tx_data;
  end

  // Sample folded in first so a coincident ss_rise sees the new count.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    mosi_smpl_d = mosi_smpl_q;
    if (sclk_rise) begin
      mosi_smpl_d = mosi2_q;
      if (bit_cnt_q != BIT_CNT_MAX) bit_cnt_d = bit_cnt_q + 1'b1;
    end
  end

  assign shift_ok = (bit_cnt_q != '0) && (bit_cnt_q < 5'd16);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shft_q      <= '0;
      bit_cnt_q   <= '0;
      mosi_smpl_q <= 1'b0;
      cmd_rcvd    <= '0;
      rdy         <= 1'b0;
      err         <= 1'b0;
      MISO        <= 1'b0;
    end else begin
      rdy  <= 1'b0;
      err  <= 1'b0;
      MISO <= shft_q[SPI_W-1];
      unique case (state_q)
        IDLE: begin
          if (ss_fall) begin
            shft_q    <= wrt ? tx_data : tx_buf_q;
            bit_cnt_q <= '0;
            state_q   <= ACTIVE;
          end
        end
        ACTIVE: begin
          bit_cnt_q   <= bit_cnt_d;
          mosi_smpl_q <= mosi_smpl_d;
          if (ss_rise) begin
            // No final SCLK fall: last bit comes from the sample.
            if (bit_cnt_d == 5'd16) begin
              cmd_rcvd <= {shft_q[SPI_W-2:0], mosi_smpl_d};
              rdy      <= 1'b1;
            end else begin
              err <= 1'b1;
            end
            state_q <= IDLE;
          end else if (sclk_fall && shift_ok) begin
            shft_q <= {shft_q[SPI_W-2:0], mosi_smpl_q};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
